// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one synchronous single-port instruction RAM between
// the fetch stage (reads) and a program loader (writes).
// BOOT holds the core while the loader fills memory. RUN gives fetch priority,
// with a starvation guard that force-grants the loader.
// Optional feature: define IMEM_MISALIGN_TRAP_EN to add a fetch_misalign output.
// With it, misaligned fetches return a NOP without touching the RAM.
module imem_port_arbiter #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32,
    parameter int STARVE_MAX  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_req,
    input  logic [INS_ADDRESS-1:0] fetch_addr,
    output logic                   fetch_gnt,
    output logic                   fetch_rvalid,
    output logic [INS_W-1:0]       fetch_rdata,
    input  logic                   ld_req,
    input  logic [INS_ADDRESS-1:0] ld_addr,
    input  logic [INS_W-1:0]       ld_wdata,
    input  logic                   ld_done,
    output logic                   ld_gnt,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [INS_ADDRESS-3:0] mem_addr,
    output logic [INS_W-1:0]       mem_wdata,
    input  logic [INS_W-1:0]       mem_rdata,
`ifdef IMEM_MISALIGN_TRAP_EN
    output logic                   fetch_misalign,
`endif
    output logic                   core_stall,
    output logic                   boot_done
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    localparam logic [7:0]       STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [INS_W-1:0] NOP_INSN   = INS_W'(32'h0000_7033);

    state_t           state, next_state;
    logic [7:0]       starve_cnt;
    logic [INS_W-1:0] rdata_hold;
    logic             misaligned;
    logic             misalign_q;

    // The byte-offset bits of both addresses only matter for the optional trap.
    logic unused_lsbs;
    assign unused_lsbs = ^{fetch_addr[1:0], ld_addr[1:0]};

`ifdef IMEM_MISALIGN_TRAP_EN
    assign misaligned = (fetch_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Grant arbitration, RAM drive and next state, all from the current state and requests.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        fetch_gnt  = 1'b0;
        ld_gnt     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        core_stall = 1'b1;
        boot_done  = 1'b0;
        if (!rst) begin
            unique case (state)
                BOOT: begin
                    ld_gnt = ld_req;
                    if (ld_done) next_state = RUN;
                end
                RUN: begin
                    core_stall = 1'b0;
                    boot_done  = 1'b1;
                    if (ld_req && starve_cnt == STARVE_LIM) begin
                        // The loader has waited long enough, so it takes this cycle.
                        ld_gnt     = 1'b1;
                        core_stall = 1'b1;
                    end else begin
                        fetch_gnt = fetch_req;
                        ld_gnt    = ld_req & ~fetch_req;
                    end
                end
                default: next_state = BOOT;
            endcase
            if (ld_gnt) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ld_addr[INS_ADDRESS-1:2];
                mem_wdata = ld_wdata;
            end else if (fetch_gnt) begin
                mem_en   = ~misaligned;
                mem_addr = fetch_addr[INS_ADDRESS-1:2];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= BOOT;
        else     state <= next_state;
    end

    // Starvation counter: counts denied loader cycles in RUN, saturating, and clears otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == RUN && ld_req && !ld_gnt) begin
            if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 8'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Read response tracking: rvalid follows a fetch grant by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_rvalid <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            fetch_rvalid <= fetch_gnt;
            misalign_q   <= fetch_gnt & misaligned;
        end
    end

    // Hold the last returned instruction so fetch_rdata stays stable between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               rdata_hold <= '0;
        else if (fetch_rvalid) rdata_hold <= fetch_rdata;
    end

    assign fetch_rdata = !fetch_rvalid ? rdata_hold :
                         misalign_q    ? NOP_INSN   : mem_rdata;

`ifdef IMEM_MISALIGN_TRAP_EN
    assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed bench for imem_port_arbiter with a behavioural
// synchronous RAM. Inputs change on the falling edge, and outputs are sampled
// 1 ns later, well away from the rising edge.
module tb_imem_port_arbiter;

    localparam int INS_ADDRESS = 9;
    localparam int INS_W       = 32;
    localparam int STARVE_MAX  = 8;

    logic                   clk;
    logic                   rst;
    logic                   fetch_req;
    logic [INS_ADDRESS-1:0] fetch_addr;
    logic                   fetch_gnt;
    logic                   fetch_rvalid;
    logic [INS_W-1:0]       fetch_rdata;
    logic                   ld_req;
    logic [INS_ADDRESS-1:0] ld_addr;
    logic [INS_W-1:0]       ld_wdata;
    logic                   ld_done;
    logic                   ld_gnt;
    logic                   mem_en;
    logic                   mem_we;
    logic [INS_ADDRESS-3:0] mem_addr;
    logic [INS_W-1:0]       mem_wdata;
    logic [INS_W-1:0]       mem_rdata;
    logic                   core_stall;
    logic                   boot_done;
`ifdef IMEM_MISALIGN_TRAP_EN
    logic                   fetch_misalign;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    imem_port_arbiter #(
        .INS_ADDRESS(INS_ADDRESS),
        .INS_W      (INS_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_rvalid(fetch_rvalid),
        .fetch_rdata (fetch_rdata),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .ld_done     (ld_done),
        .ld_gnt      (ld_gnt),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
`ifdef IMEM_MISALIGN_TRAP_EN
        .fetch_misalign(fetch_misalign),
`endif
        .core_stall  (core_stall),
        .boot_done   (boot_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM driven by the DUT.
    logic [INS_W-1:0] ram [0:(2**(INS_ADDRESS-2))-1];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata     <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one full clock: through the rising edge to the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold fetch and loader requests together: 8 denied cycles, then a forced loader grant.
    task automatic starve_run();
        fetch_req  = 1'b1;
        fetch_addr = 9'h084;
        ld_req     = 1'b1;
        ld_addr    = 9'h010;
        ld_wdata   = 32'hCAFE_0004;
        for (int i = 1; i <= STARVE_MAX; i++) begin
            #1;
            check("starve_fetch_gnt", 32'(fetch_gnt), 32'd1);
            check("starve_ld_denied", 32'(ld_gnt), 32'd0);
            check("starve_no_stall", 32'(core_stall), 32'd0);
            tick();
        end
        #1;
        check("force_ld_gnt", 32'(ld_gnt), 32'd1);
        check("force_fetch_gnt", 32'(fetch_gnt), 32'd0);
        check("force_core_stall", 32'(core_stall), 32'd1);
        check("force_mem_we", 32'(mem_we), 32'd1);
        check("force_mem_addr", 32'(mem_addr), 32'd4);
        tick();
        #1;
        check("resume_fetch_gnt", 32'(fetch_gnt), 32'd1);
        check("resume_ld_gnt", 32'(ld_gnt), 32'd0);
        tick();
        ld_req = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        ld_req     = 1'b0;
        ld_addr    = '0;
        ld_wdata   = '0;
        ld_done    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
        check("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rvalid", 32'(fetch_rvalid), 32'd0);
        check("rst_rdata", fetch_rdata, 32'd0);
        check("rst_core_stall", 32'(core_stall), 32'd1);
        check("rst_boot_done", 32'(boot_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // BOOT: fetch is refused.
        fetch_req  = 1'b1;
        fetch_addr = 9'h084;
        #1;
        check("boot_fetch_gnt", 32'(fetch_gnt), 32'd0);
        check("boot_core_stall", 32'(core_stall), 32'd1);
        check("boot_mem_en", 32'(mem_en), 32'd0);
        tick();
        check("boot_no_rvalid", 32'(fetch_rvalid), 32'd0);

        // BOOT: loader fills words 33 and 34 while fetch keeps requesting.
        ld_req   = 1'b1;
        ld_addr  = 9'h084;
        ld_wdata = 32'h1111_0033;
        #1;
        check("boot_ld_gnt", 32'(ld_gnt), 32'd1);
        check("boot_ld_fetch_gnt", 32'(fetch_gnt), 32'd0);
        check("boot_ld_mem_we", 32'(mem_we), 32'd1);
        check("boot_ld_addr33", 32'(mem_addr), 32'd33);
        tick();
        ld_addr  = 9'h08B;
        ld_wdata = 32'h2222_0034;
        #1;
        check("boot_ld_addr34_lsb_ignored", 32'(mem_addr), 32'd34);
        tick();

        // Last write with ld_done in the same cycle: the write still completes.
        ld_addr  = 9'h008;
        ld_wdata = 32'h0050_2223;
        ld_done  = 1'b1;
        #1;
        check("done_ld_gnt", 32'(ld_gnt), 32'd1);
        check("done_mem_we", 32'(mem_we), 32'd1);
        check("done_mem_addr", 32'(mem_addr), 32'd2);
        check("done_mem_wdata", mem_wdata, 32'h0050_2223);
        check("done_still_boot", 32'(boot_done), 32'd0);
        tick();
        ld_req  = 1'b0;
        ld_done = 1'b0;

        // RUN: back-to-back fetches 0x84, 0x88, 0x08.
        fetch_addr = 9'h084;
        #1;
        check("run_boot_done", 32'(boot_done), 32'd1);
        check("run_core_stall", 32'(core_stall), 32'd0);
        check("run_fetch_gnt", 32'(fetch_gnt), 32'd1);
        check("run_mem_en", 32'(mem_en), 32'd1);
        check("run_mem_we", 32'(mem_we), 32'd0);
        check("run_mem_addr", 32'(mem_addr), 32'd33);
        tick();
        fetch_addr = 9'h088;
        #1;
        check("b2b_rvalid1", 32'(fetch_rvalid), 32'd1);
        check("b2b_rdata1", fetch_rdata, 32'h1111_0033);
        check("b2b_gnt2", 32'(fetch_gnt), 32'd1);
        tick();
        fetch_addr = 9'h008;
        #1;
        check("b2b_rvalid2", 32'(fetch_rvalid), 32'd1);
        check("b2b_rdata2", fetch_rdata, 32'h2222_0034);
        tick();
        fetch_req = 1'b0;
        #1;
        check("b2b_rvalid3", 32'(fetch_rvalid), 32'd1);
        check("b2b_rdata3_done_write", fetch_rdata, 32'h0050_2223);
        tick();
        #1;
        check("idle_rvalid", 32'(fetch_rvalid), 32'd0);
        check("idle_rdata_hold", fetch_rdata, 32'h0050_2223);

        // ld_done in RUN is ignored.
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        #1;
        check("run_ld_done_ignored", 32'(boot_done), 32'd1);

        // Loader alone in RUN is granted immediately.
        ld_req   = 1'b1;
        ld_addr  = 9'h010;
        ld_wdata = 32'hCAFE_0004;
        #1;
        check("run_ld_alone_gnt", 32'(ld_gnt), 32'd1);
        check("run_ld_alone_stall", 32'(core_stall), 32'd0);
        tick();
        ld_req = 1'b0;

        // Starvation guard.
        starve_run();

        // A cycle with ld_req low clears partial starvation.
        fetch_req = 1'b1;
        ld_req    = 1'b1;
        repeat (5) tick();
        ld_req = 1'b0;
        tick();
        starve_run();
        fetch_req = 1'b0;
        tick();

        // Reset the cycle after a fetch grant drops the pending response.
        fetch_req  = 1'b1;
        fetch_addr = 9'h084;
        #1;
        check("pre_rst_fetch_gnt", 32'(fetch_gnt), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_rvalid", 32'(fetch_rvalid), 32'd0);
        check("midrst_boot_done", 32'(boot_done), 32'd0);
        check("midrst_core_stall", 32'(core_stall), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_fetch_gnt", 32'(fetch_gnt), 32'd0);
        check("postrst_rvalid", 32'(fetch_rvalid), 32'd0);
        tick();
        fetch_req = 1'b0;

`ifdef IMEM_MISALIGN_TRAP_EN
        ld_done = 1'b1;
        tick();
        ld_done    = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 9'h086;
        #1;
        check("mis_fetch_gnt", 32'(fetch_gnt), 32'd1);
        check("mis_mem_en", 32'(mem_en), 32'd0);
        tick();
        fetch_req = 1'b0;
        #1;
        check("mis_flag", 32'(fetch_misalign), 32'd1);
        check("mis_rvalid", 32'(fetch_rvalid), 32'd1);
        check("mis_rdata_nop", fetch_rdata, 32'h0000_7033);
        tick();
        #1;
        check("mis_flag_clear", 32'(fetch_misalign), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
